mips_instr_encoder: RTL and testbench

- Encodes decoded operation fields back into 32-bit MIPS instruction words. It is the inverse of the opcode-to-control decode path.
- Accepts one operation per valid/ready handshake, encodes it, and buffers it in a small FIFO.
- Each output word is presented with a sequential word address, ready to be written into instruction memory.
- Sits between the test/program-generation front end and the instruction-memory write port.

---
 rtl/mips_instr_encoder_if.sv | 35 +++
 rtl/mips_instr_encoder.sv | 128 ++++++++++++
 tb/tb_mips_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_if.sv
// Encoder bus: decoded operation fields in (valid/ready) and encoded words out (valid/ready).
// Latency: n/a (signal bundle only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
//
// Modports:
//   slave  - the encoder: takes operation fields, produces instruction words with addresses.
//   master - the front end / memory writer side: drives fields and out_ready, observes the rest.
interface mips_instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op_sel;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_word;
   logic [ADDR_W-1:0] out_addr;

   modport slave (
      input  in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready,
      output in_ready, out_valid, out_word, out_addr
   );

   modport master (
      output in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready,
      input  in_ready, out_valid, out_word, out_addr
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes decoded MIPS operation fields into 32-bit words, buffered in a DEPTH-entry FIFO.
// Latency: 1 cycle push-to-visible (no bypass); head word read combinationally from storage.
// Backpressure: in_ready = !full (no push-through when full); out_valid = !empty.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   clear         - synchronous flush of FIFO and address counter (err_count retained)
//   bus (slave)   - operation fields in, {out_word, out_addr} out, valid/ready both sides
//   err_pulse     - registered one-cycle pulse per accepted illegal op_sel
//   err_count     - saturating count of accepted illegal ops
module mips_instr_encoder #(
   parameter int          DEPTH     = 4,
   parameter int          ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   mips_instr_encoder_if.slave         bus,
   output logic                        err_pulse,
   output logic [7:0]                  err_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_ANDI  = 6'b001100;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_LUI   = 6'b001111;
   localparam logic [5:0] OPC_ADDIU = 6'b001001;
   localparam logic [5:0] OPC_SLTI  = 6'b001010;
   localparam logic [5:0] OPC_J     = 6'b000010;

   logic [31:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] addr;

   logic [31:0] word_enc;
   logic        legal;
   logic        full;
   logic        empty;
   logic        push_fire;
   logic        wr_en;
   logic        rd_en;

   // Field packing per instruction format; unused fields of a format are dropped.
   always_comb begin
      word_enc = '0;
      legal    = 1'b1;
      unique case (bus.op_sel)
         4'd0:    word_enc = {OPC_RTYPE, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
         4'd1:    word_enc = {OPC_BEQ,   bus.rs, bus.rt, bus.imm};
         4'd2:    word_enc = {OPC_LW,    bus.rs, bus.rt, bus.imm};
         4'd3:    word_enc = {OPC_SW,    bus.rs, bus.rt, bus.imm};
         4'd4:    word_enc = {OPC_ADDI,  bus.rs, bus.rt, bus.imm};
         4'd5:    word_enc = {OPC_ANDI,  bus.rs, bus.rt, bus.imm};
         4'd6:    word_enc = {OPC_ORI,   bus.rs, bus.rt, bus.imm};
         4'd7:    word_enc = {OPC_LUI,   5'b00000, bus.rt, bus.imm};  // lui has no source register
         4'd8:    word_enc = {OPC_ADDIU, bus.rs, bus.rt, bus.imm};
         4'd9:    word_enc = {OPC_SLTI,  bus.rs, bus.rt, bus.imm};
         4'd10:   word_enc = {OPC_J,     bus.target};
         default: legal    = 1'b0;
      endcase
   end

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // Flow control depends on occupancy only; clear does not gate in_ready.
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_word  = mem[rd_ptr];
   assign bus.out_addr  = addr;

   // Illegal ops complete the handshake but never reach storage or the address counter.
   assign push_fire = bus.in_valid && !full && !clear;
   assign wr_en     = push_fire && legal;
   assign rd_en     = !empty && bus.out_ready && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         addr      <= BASE_C;
         err_pulse <= 1'b0;
         err_count <= '0;
         // Storage is cleared so the head reads as zero out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         err_pulse <= push_fire && !legal;
         if (push_fire && !legal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end

         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= BASE_C;
         end else begin
            if (wr_en) begin
               mem[wr_ptr] <= word_enc;
               wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
               rd_ptr <= rd_ptr + 1'b1;
               addr   <= addr + 1'b1;
            end
            case ({wr_en, rd_en})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: encoding table, handshake, FIFO full,
// illegal ops, address wrap, clear and asynchronous reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mips_instr_encoder;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       err_pulse;
   logic [7:0] err_count;

   mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .bus       (bus),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[13];

   function automatic vec_t mkv(input logic [3:0] op, input logic [4:0] r_s, r_t, r_d, sh,
                                input logic [5:0] fn, input logic [15:0] im,
                                input logic [25:0] tg, input logic [31:0] ex);
      vec_t v;
      v.op = op; v.rs = r_s; v.rt = r_t; v.rd = r_d; v.sh = sh;
      v.fn = fn; v.imm = im; v.tgt = tg; v.exp = ex;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] r_s, r_t, r_d, sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
      bus.in_valid = 1'b1;
      bus.op_sel   = op;
      bus.rs       = r_s;
      bus.rt       = r_t;
      bus.rd       = r_d;
      bus.shamt    = sh;
      bus.funct    = fn;
      bus.imm      = im;
      bus.target   = tg;
   endtask

   // Watchdog: the test is a few thousand cycles at most.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   logic [ADDR_W-1:0] exp_addr;
   logic [31:0]       q[$];
   logic [31:0]       w;
   int                pushes, pops, guard;
   logic              push_now, pop_now;

   initial begin
      vt[0]  = mkv(4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h5555, 26'h3FFFFFF, 32'h00221820);
      vt[1]  = mkv(4'd2,  5'd29, 5'd8,  5'd7,  5'd7,  6'h3F, 16'h0004, 26'h0,       32'h8FA80004);
      vt[2]  = mkv(4'd10, 5'd9,  5'd9,  5'd9,  5'd9,  6'h3F, 16'hFFFF, 26'h0000100, 32'h08000100);
      vt[3]  = mkv(4'd7,  5'd5,  5'd1,  5'd0,  5'd0,  6'h00, 16'h1234, 26'h0,       32'h3C011234);
      vt[4]  = mkv(4'd1,  5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1022FFFF);
      vt[5]  = mkv(4'd3,  5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008);
      vt[6]  = mkv(4'd4,  5'd0,  5'd4,  5'd31, 5'd31, 6'h3F, 16'h7FFF, 26'h3FFFFFF, 32'h20047FFF);
      vt[7]  = mkv(4'd5,  5'd3,  5'd3,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0,       32'h306300FF);
      vt[8]  = mkv(4'd6,  5'd31, 5'd0,  5'd0,  5'd0,  6'h00, 16'hABCD, 26'h0,       32'h37E0ABCD);
      vt[9]  = mkv(4'd8,  5'd4,  5'd5,  5'd0,  5'd0,  6'h00, 16'h8000, 26'h0,       32'h24858000);
      vt[10] = mkv(4'd9,  5'd2,  5'd9,  5'd0,  5'd0,  6'h00, 16'h0001, 26'h0,       32'h28490001);
      vt[11] = mkv(4'd0,  5'd0,  5'd9,  5'd10, 5'd31, 6'h00, 16'h0,    26'h0,       32'h000957C0);
      vt[12] = mkv(4'd10, 5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0,    26'h3FFFFFF, 32'h0BFFFFFF);

      // ---------------- reset ----------------
      rst_n = 1'b0;
      clear = 1'b0;
      drive(4'd0, '0, '0, '0, '0, '0, '0, '0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_word",  bus.out_word, 0);
      chk("rst_out_addr",  bus.out_addr, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_count", err_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      exp_addr = '0;

      // ---------------- encoding table ----------------
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].fn, vt[i].imm, vt[i].tgt);
         bus.out_ready = 1'b0;
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk($sformatf("tbl%0d_valid", i), bus.out_valid, 1);
         chk($sformatf("tbl%0d_word", i),  bus.out_word, vt[i].exp);
         chk($sformatf("tbl%0d_addr", i),  bus.out_addr, exp_addr);
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         exp_addr++;
         chk($sformatf("tbl%0d_drained", i), bus.out_valid, 0);
      end

      // ---------------- back-to-back lw then j, out_ready held ----------------
      bus.out_ready = 1'b1;
      drive(4'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
      @(negedge clk);
      chk("b2b_lw_word", bus.out_word, 32'h8FA80004);
      chk("b2b_lw_addr", bus.out_addr, exp_addr);
      drive(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000100);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("b2b_j_valid", bus.out_valid, 1);
      chk("b2b_j_word",  bus.out_word, 32'h08000100);
      chk("b2b_j_addr",  bus.out_addr, exp_addr + 8'd1);
      @(negedge clk);
      chk("b2b_drained", bus.out_valid, 0);
      exp_addr = exp_addr + 8'd2;
      bus.out_ready = 1'b0;

      // ---------------- fill to full, 5th push refused ----------------
      for (int k = 0; k < 4; k++) begin
         drive(4'd0, 5'd0, 5'd0, 5'(k + 1), 5'd0, 6'h20, 16'h0, 26'h0);
         @(negedge clk);
         chk($sformatf("fill%0d_in_ready", k), bus.in_ready, (k < 3) ? 1 : 0);
      end
      drive(4'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20, 16'h0, 26'h0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_head_stable", bus.out_word, 32'h00000820);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 32'h00000020 | (32'(k + 1) << 11);
         chk($sformatf("drain%0d_valid", k), bus.out_valid, 1);
         chk($sformatf("drain%0d_word", k),  bus.out_word, w);
         chk($sformatf("drain%0d_addr", k),  bus.out_addr, exp_addr);
         @(negedge clk);
         exp_addr++;
      end
      chk("drain_fifth_not_taken", bus.out_valid, 0);
      bus.out_ready = 1'b0;

      // ---------------- illegal ops ----------------
      drive(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'h5, 16'h6, 26'h7);
      chk("ill_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ill_err_pulse", err_pulse, 1);
      chk("ill_err_count", err_count, 1);
      chk("ill_no_write",  bus.out_valid, 0);
      chk("ill_addr_same", bus.out_addr, exp_addr);
      @(negedge clk);
      chk("ill_pulse_1cyc", err_pulse, 0);
      drive(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 0 || i == 150 || i == 299) chk($sformatf("ill_b2b_pulse%0d", i), err_pulse, 1);
      end
      bus.in_valid = 1'b0;
      chk("ill_err_sat", err_count, 255);
      chk("ill_b2b_no_write", bus.out_valid, 0);
      @(negedge clk);
      chk("ill_pulse_end", err_pulse, 0);
      chk("ill_err_hold", err_count, 255);

      // ---------------- stream 256 words, address wraps ----------------
      pushes = 0;
      pops   = 0;
      guard  = 0;
      bus.out_ready = 1'b1;
      while (pops < 256 && guard < 600) begin
         guard++;
         if (q.size() > 0) begin
            chk("st_word", bus.out_word, q[0]);
            chk("st_addr", bus.out_addr, exp_addr);
         end else begin
            chk("st_empty", bus.out_valid, 0);
         end
         chk("st_in_ready", bus.in_ready, (q.size() < DEPTH) ? 1 : 0);
         if (pushes < 256) drive(4'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'(pushes), 26'h0);
         else bus.in_valid = 1'b0;
         push_now = bus.in_valid && (q.size() < DEPTH);
         pop_now  = (q.size() > 0);
         @(negedge clk);
         if (pop_now) begin
            void'(q.pop_front());
            pops++;
            exp_addr++;
         end
         if (push_now) begin
            q.push_back(32'h20010000 | 32'(pushes));
            pushes++;
         end
      end
      if (guard >= 600) chk("st_cycle_budget", 32'(pops), 256);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("st_final_addr", bus.out_addr, exp_addr);

      // ---------------- clear with 2 buffered and a push offered ----------------
      drive(4'd6, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1111, 26'h0);
      @(negedge clk);
      drive(4'd6, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h2222, 26'h0);
      @(negedge clk);
      chk("clr_pre_valid", bus.out_valid, 1);
      drive(4'd6, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h3333, 26'h0);
      clear = 1'b1;
      chk("clr_pre_in_ready", bus.in_ready, 1);
      @(negedge clk);
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr_out_valid", bus.out_valid, 0);
      chk("clr_out_addr",  bus.out_addr, 0);
      chk("clr_in_ready",  bus.in_ready, 1);
      chk("clr_err_keep",  err_count, 255);
      @(negedge clk);
      chk("clr_push_dropped", bus.out_valid, 0);

      // ---------------- async reset mid-stream with 3 buffered ----------------
      for (int k = 0; k < 3; k++) begin
         drive(4'd8, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'(k), 26'h0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("ar_pre_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", bus.out_valid, 0);
      chk("ar_in_ready",  bus.in_ready, 1);
      chk("ar_err_count", err_count, 0);
      chk("ar_out_word",  bus.out_word, 0);
      chk("ar_out_addr",  bus.out_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_stays_empty", bus.out_valid, 0);
      drive(4'd7, 5'd5, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ar_after_word", bus.out_word, 32'h3C011234);
      chk("ar_after_addr", bus.out_addr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
